// File: rtl/alu_op_pkg.sv
// ----------------------------------------------------------------------------
// alu_op_pkg
// Shared constants for the ALU operation issuer:
//   - ALUSEL encodings driven to the ALU result multiplexer
//   - ALUOp codes coming from the control unit
//   - RISC-V funct3 values relevant to the OP/OP-IMM decode
//   - issuer FSM state encoding
//   - helper to classify shift selections
// ----------------------------------------------------------------------------
package alu_op_pkg;

    // ALUSEL codes understood by the result multiplexer
    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_SUB = 3'b010;
    localparam logic [2:0] SEL_ADD = 3'b011;
    localparam logic [2:0] SEL_SLL = 3'b100;
    localparam logic [2:0] SEL_SRA = 3'b101;

    // ALUOp codes from the control unit
    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
    localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

    // funct3 values of the integer OP / OP-IMM groups
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Issuer FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

    // True when the selection is a shift whose B operand is a shift amount
    function automatic logic is_shift(input logic [2:0] sel);
        return (sel == SEL_SLL) || (sel == SEL_SRA);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational ALUOp/funct3/funct7[5] decoder producing the ALUSEL
// code and an illegal flag for operations the ALU mux cannot perform.
// Ports:
//   aluop    in  2  control-unit ALUOp
//   funct3   in  3  instruction funct3
//   funct7b5 in  1  instruction bit 30
//   is_rtype in  1  register-register instruction (SUB only allowed here)
//   sel      out 3  ALUSEL code (SEL_AND when illegal, value unused)
//   illegal  out 1  operation not supported
// ----------------------------------------------------------------------------
module alu_op_decode (
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] sel,
    output logic       illegal
);
    import alu_op_pkg::*;

    // ALUOp / funct decode into ALUSEL plus illegal flag
    always_comb begin
        sel     = SEL_AND;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: sel = SEL_ADD;
            ALUOP_SUB: sel = SEL_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    F3_AND: sel = SEL_AND;
                    F3_OR:  sel = SEL_OR;
                    F3_ADD_SUB: begin
                        // funct7b5 on an I-type is immediate bits, not SUB
                        if (is_rtype && funct7b5) begin
                            sel = SEL_SUB;
                        end else begin
                            sel = SEL_ADD;
                        end
                    end
                    F3_SLL: begin
                        if (!funct7b5) begin
                            sel = SEL_SLL;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    F3_SRL_SRA: begin
                        // only the arithmetic right shift exists in the mux
                        if (funct7b5) begin
                            sel = SEL_SRA;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            ALUOP_ILLEGAL: illegal = 1'b1;
            default:       illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// ----------------------------------------------------------------------------
// alu_op_issuer
// Sequencing front end for the ALU result multiplexer. Accepts one request at
// a time, decodes it to ALUSEL, drives registered operands/ALUSEL to the ALU,
// waits SETTLE_CYCLES, captures ALUOut and returns it over a valid/ready
// response handshake. Illegal operations skip the ALU and respond at once.
//
// Optional build macro: ALU_OP_ISSUER_SHAMT_MASK_EN
//   defined   -> SLL/SRA drive alu_b with only req_b[4:0] (RV32 shamt)
//   undefined -> alu_b = req_b for every operation
//
// Parameters: WIDTH (operand width), SETTLE_CYCLES (1..15)
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_valid/req_ready            request handshake
//   req_aluop/funct3/funct7b5/is_rtype  operation selection
//   req_a, req_b                   operands
//   alu_sel, alu_a, alu_b          registered drive to ALU + mux
//   alu_out                        result from the mux
//   resp_valid/resp_ready          response handshake
//   resp_data/resp_zero/resp_illegal  response payload
// ----------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic             req_is_rtype,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_illegal
);
    import alu_op_pkg::*;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [3:0]       cnt_r;
    logic [2:0]       dec_sel_s;
    logic             dec_illegal_s;
    logic             accept_s;
    logic [WIDTH-1:0] alu_b_load_s;

    logic             req_ready_r;
    logic             resp_valid_r;
    logic [2:0]       alu_sel_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [WIDTH-1:0] resp_data_r;
    logic             resp_zero_r;
    logic             resp_illegal_r;

    alu_op_decode u_decode (
        .aluop    (req_aluop),
        .funct3   (req_funct3),
        .funct7b5 (req_funct7b5),
        .is_rtype (req_is_rtype),
        .sel      (dec_sel_s),
        .illegal  (dec_illegal_s)
    );

    // req_ready_r is only high in IDLE, so this is the acceptance event
    assign accept_s = req_valid && req_ready_r;

    // Operand B as it will be presented to the ALU
    always_comb begin
        alu_b_load_s = req_b;
`ifdef ALU_OP_ISSUER_SHAMT_MASK_EN
        if (is_shift(dec_sel_s)) begin
            alu_b_load_s = {{(WIDTH-5){1'b0}}, req_b[4:0]};
        end else begin
            alu_b_load_s = req_b;
        end
`endif
    end

    // Next-state logic of the issue sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (dec_illegal_s) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // <= also catches a zero count so the FSM can never stall
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_CAPTURE: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

    // Settle counter: loaded on acceptance, counts down while issuing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == ST_ISSUE) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // ALU drive registers; illegal requests leave the ALU untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_sel_r <= 3'b000;
            alu_a_r   <= {WIDTH{1'b0}};
            alu_b_r   <= {WIDTH{1'b0}};
        end else if (accept_s && !dec_illegal_s) begin
            alu_sel_r <= dec_sel_s;
            alu_a_r   <= req_a;
            alu_b_r   <= alu_b_load_s;
        end
    end

    // Response payload; held outside capture/acceptance so RESP is stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data_r    <= {WIDTH{1'b0}};
            resp_zero_r    <= 1'b0;
            resp_illegal_r <= 1'b0;
        end else if (accept_s && dec_illegal_s) begin
            resp_data_r    <= {WIDTH{1'b0}};
            resp_zero_r    <= 1'b1;
            resp_illegal_r <= 1'b1;
        end else if (state_r == ST_CAPTURE) begin
            resp_data_r    <= alu_out;
            resp_zero_r    <= (alu_out == {WIDTH{1'b0}});
            resp_illegal_r <= 1'b0;
        end
    end

    assign req_ready    = req_ready_r;
    assign resp_valid   = resp_valid_r;
    assign alu_sel      = alu_sel_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign resp_data    = resp_data_r;
    assign resp_zero    = resp_zero_r;
    assign resp_illegal = resp_illegal_r;

endmodule

// File: tb/tb_alu_op_issuer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_issuer
// Directed self-checking bench for alu_op_issuer (SETTLE_CYCLES = 1).
// A behavioural ALU + mux answers alu_sel either with real arithmetic or
// with a fixed per-selection table so decode results are unambiguous.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_alu_op_issuer;

    localparam int W = 32;
    localparam int S = 1;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_aluop;
    logic [2:0]   req_funct3;
    logic         req_funct7b5;
    logic         req_is_rtype;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_zero;
    logic         resp_illegal;

    logic use_table;
    int   n_checks;
    int   n_fail;

    alu_op_issuer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_aluop    (req_aluop),
        .req_funct3   (req_funct3),
        .req_funct7b5 (req_funct7b5),
        .req_is_rtype (req_is_rtype),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_sel      (alu_sel),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_zero    (resp_zero),
        .resp_illegal (resp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU and result mux
    always_comb begin
        alu_out = 32'd0;
        if (use_table) begin
            case (alu_sel)
                3'b000:  alu_out = 32'd23;
                3'b001:  alu_out = 32'd1;
                3'b010:  alu_out = 32'd2;
                3'b011:  alu_out = 32'd10;
                3'b100:  alu_out = 32'd5;
                3'b101:  alu_out = 32'd100;
                default: alu_out = 32'd0;
            endcase
        end else begin
            case (alu_sel)
                3'b000:  alu_out = alu_a & alu_b;
                3'b001:  alu_out = alu_a | alu_b;
                3'b010:  alu_out = alu_a - alu_b;
                3'b011:  alu_out = alu_a + alu_b;
                3'b100:  alu_out = alu_a << alu_b[4:0];
                3'b101:  alu_out = $signed(alu_a) >>> alu_b[4:0];
                default: alu_out = 32'd0;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Sends one request (resp_ready assumed 1) and reports what was seen.
    // lat = falling edges after the accepting edge until resp_valid, -1 on timeout.
    task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic rt, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] data, output logic zero, output logic ill,
                         output int lat, output logic [2:0] sel0,
                         output logic [W-1:0] a0, output logic [W-1:0] b0,
                         output logic held);
        int w;
        lat = -1; held = 1'b1; data = 32'd0; zero = 1'b0; ill = 1'b0;
        sel0 = 3'b000; a0 = 32'd0; b0 = 32'd0;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) return;
        req_valid = 1'b1; req_aluop = op; req_funct3 = f3; req_funct7b5 = f7;
        req_is_rtype = rt; req_a = a; req_b = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        sel0 = alu_sel; a0 = alu_a; b0 = alu_b;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (alu_sel !== sel0 || alu_a !== a0 || alu_b !== b0) held = 1'b0;
        end
        if (!resp_valid) begin
            lat = -1;
            return;
        end
        data = resp_data; zero = resp_zero; ill = resp_illegal;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || alu_sel !== 3'b000 ||
            resp_data !== 32'd0 || alu_a !== 32'd0 || resp_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b sel=%b data=%h a=%h ill=%b, expected all 0",
                     req_ready, resp_valid, alu_sel, resp_data, alu_a, resp_illegal);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        // abort an ADD while it is in ISSUE
        req_valid = 1'b1; req_aluop = 2'b00; req_a = 32'd3; req_b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (alu_sel !== 3'b011 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_issue_entry: got sel=%b ready=%b expected 011/0", alu_sel, req_ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || alu_sel !== 3'b000 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: got valid=%b sel=%b ready=%b expected 0/000/0",
                     resp_valid, alu_sel, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midop_ready: got %b expected 1", req_ready);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_resp: got %0d response cycles expected 0", seen);
        end
    endtask

    task automatic test_add();
        logic [W-1:0] d, a0, b0;
        logic z, il, hd;
        logic [2:0] s0;
        int lat;
        use_table = 1'b0;
        do_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd10, 32'd5, d, z, il, lat, s0, a0, b0, hd);
        n_checks++;
        if (d !== 32'd15 || z !== 1'b0 || il !== 1'b0) begin
            n_fail++;
            $display("FAIL add_result: got data=%0d zero=%b ill=%b expected 15/0/0", d, z, il);
        end
        n_checks++;
        if (lat != S + 2) begin
            n_fail++;
            $display("FAIL add_latency: got %0d expected %0d", lat, S + 2);
        end
        n_checks++;
        if (s0 !== 3'b011 || a0 !== 32'd10 || b0 !== 32'd5 || hd !== 1'b1) begin
            n_fail++;
            $display("FAIL add_drive: got sel=%b a=%0d b=%0d held=%b expected 011/10/5/1", s0, a0, b0, hd);
        end
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic        f7;
        logic        rt;
        logic        ill;
        logic [2:0]  sel;
        logic [31:0] data;
    } vec_t;

    task automatic test_decode_sweep();
        vec_t v [12];
        logic [W-1:0] d, a0, b0;
        logic z, il, hd;
        logic [2:0] s0, prev;
        int lat;
        v[0]  = '{3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 32'd23};
        v[1]  = '{3'b110, 1'b0, 1'b0, 1'b0, 3'b001, 32'd1};
        v[2]  = '{3'b000, 1'b1, 1'b1, 1'b0, 3'b010, 32'd2};
        v[3]  = '{3'b000, 1'b1, 1'b0, 1'b0, 3'b011, 32'd10};
        v[4]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b011, 32'd10};
        v[5]  = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b100, 32'd5};
        v[6]  = '{3'b101, 1'b1, 1'b0, 1'b0, 3'b101, 32'd100};
        v[7]  = '{3'b010, 1'b0, 1'b1, 1'b1, 3'b000, 32'd0};
        v[8]  = '{3'b011, 1'b0, 1'b0, 1'b1, 3'b000, 32'd0};
        v[9]  = '{3'b100, 1'b0, 1'b0, 1'b1, 3'b000, 32'd0};
        v[10] = '{3'b101, 1'b0, 1'b1, 1'b1, 3'b000, 32'd0};
        v[11] = '{3'b001, 1'b1, 1'b1, 1'b1, 3'b000, 32'd0};
        use_table = 1'b1;
        prev = 3'b011;  // left by test_add
        for (int i = 0; i < 12; i++) begin
            do_op(2'b10, v[i].f3, v[i].f7, v[i].rt, 32'h11, 32'h22, d, z, il, lat, s0, a0, b0, hd);
            n_checks++;
            if (d !== v[i].data || il !== v[i].ill) begin
                n_fail++;
                $display("FAIL sweep_%0d_result: got data=%0d ill=%b expected %0d/%b",
                         i, d, il, v[i].data, v[i].ill);
            end
            n_checks++;
            if (lat != (v[i].ill ? 1 : S + 2)) begin
                n_fail++;
                $display("FAIL sweep_%0d_latency: got %0d expected %0d", i, lat, v[i].ill ? 1 : S + 2);
            end
            n_checks++;
            if (s0 !== (v[i].ill ? prev : v[i].sel)) begin
                n_fail++;
                $display("FAIL sweep_%0d_sel: got %b expected %b", i, s0, v[i].ill ? prev : v[i].sel);
            end
            if (!v[i].ill) begin
                n_checks++;
                if (z !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_%0d_zero: got %b expected 0", i, z);
                end
                prev = v[i].sel;
            end
        end
        use_table = 1'b0;
    endtask

    task automatic test_illegal_aluop();
        logic [W-1:0] d, a0, b0;
        logic z, il, hd;
        logic [2:0] s0;
        int lat;
        do_op(2'b00, 3'b000, 1'b0, 1'b0, 32'hAA, 32'h1, d, z, il, lat, s0, a0, b0, hd);
        do_op(2'b11, 3'b000, 1'b0, 1'b1, 32'h55, 32'h2, d, z, il, lat, s0, a0, b0, hd);
        n_checks++;
        if (il !== 1'b1 || d !== 32'd0 || lat != 1) begin
            n_fail++;
            $display("FAIL illegal_aluop: got ill=%b data=%0d lat=%0d expected 1/0/1", il, d, lat);
        end
        n_checks++;
        if (s0 !== 3'b011 || a0 !== 32'hAA || b0 !== 32'h1) begin
            n_fail++;
            $display("FAIL illegal_keep_drive: got sel=%b a=%h b=%h expected 011/aa/1", s0, a0, b0);
        end
    endtask

    task automatic test_backpressure();
        int w;
        int bad;
        use_table = 1'b0;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_aluop = 2'b01; req_a = 32'd7; req_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        // second request stays pending for the whole busy period
        req_aluop = 2'b00; req_a = 32'd3; req_b = 32'd4;
        w = 0; bad = 0;
        while (!resp_valid && w < 20) begin
            if (req_ready !== 1'b0) bad++;
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            if (resp_valid !== 1'b1 || resp_data !== 32'd0 || resp_zero !== 1'b1 ||
                resp_illegal !== 1'b0 || req_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d bad cycles, last valid=%b data=%0d zero=%b ready=%b expected 1/0/1/0",
                     bad, resp_valid, resp_data, resp_zero, req_ready);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", resp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0 || alu_a !== 32'd3 || alu_sel !== 3'b011) begin
            n_fail++;
            $display("FAIL bp_second_accept: got ready=%b a=%0d sel=%b expected 0/3/011",
                     req_ready, alu_a, alu_sel);
        end
        w = 0;
        while (!resp_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd7) begin
            n_fail++;
            $display("FAIL bp_second_result: got valid=%b data=%0d expected 1/7", resp_valid, resp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t [3];
        int k;
        k = 0;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_aluop = 2'b00; req_a = 32'd1; req_b = 32'd2;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1 && k < 3) begin
                t[k] = i;
                k++;
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (k != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses expected at least 3", k);
        end else begin
            n_checks++;
            if (t[1] - t[0] != S + 3 || t[2] - t[1] != S + 3) begin
                n_fail++;
                $display("FAIL b2b_period: got %0d,%0d expected %0d", t[1] - t[0], t[2] - t[1], S + 3);
            end
        end
        for (int i = 0; i < 10; i++) @(negedge clk);
    endtask

    task automatic test_shamt();
        logic [W-1:0] d, a0, b0, exp_b;
        logic z, il, hd;
        logic [2:0] s0;
        int lat;
`ifdef ALU_OP_ISSUER_SHAMT_MASK_EN
        exp_b = 32'h0000_0003;
`else
        exp_b = 32'h0000_0023;
`endif
        use_table = 1'b0;
        do_op(2'b10, 3'b001, 1'b0, 1'b1, 32'd1, 32'h23, d, z, il, lat, s0, a0, b0, hd);
        n_checks++;
        if (b0 !== exp_b || s0 !== 3'b100 || d !== 32'd8) begin
            n_fail++;
            $display("FAIL shamt_sll: got b=%h sel=%b data=%0d expected %h/100/8", b0, s0, d, exp_b);
        end
        do_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'h23, d, z, il, lat, s0, a0, b0, hd);
        n_checks++;
        if (b0 !== 32'h23 || d !== 32'h24) begin
            n_fail++;
            $display("FAIL shamt_add_unmasked: got b=%h data=%h expected 23/24", b0, d);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        use_table = 1'b0;
        rst = 1'b1; req_valid = 1'b0; req_aluop = 2'b00; req_funct3 = 3'b000;
        req_funct7b5 = 1'b0; req_is_rtype = 1'b0; req_a = 32'd0; req_b = 32'd0;
        resp_ready = 1'b1;
        test_reset();
        test_add();
        test_decode_sweep();
        test_illegal_aluop();
        test_backpressure();
        test_back_to_back();
        test_shamt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
